// File: rtl/dist_uart_formatter_if.sv
// rtl/dist_uart_formatter_if.sv - measurement input and UART TX handshake bundle for dist_uart_formatter
interface dist_uart_formatter_if;
    logic [7:0] dist_data;
    logic       done;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       sending;
    logic       overrun;

    modport master (
        input  dist_data, done, tx_busy,
        output tx_start, tx_data, sending, overrun
    );

    modport slave (
        output dist_data, done, tx_busy,
        input  tx_start, tx_data, sending, overrun
    );
endinterface

// File: rtl/dist_uart_formatter.sv
// rtl/dist_uart_formatter.sv - distance-to-ASCII frame ("DDDcm\r\n") streamer into a start/busy UART TX
module dist_uart_formatter #(
    parameter bit BLANK_ZERO  = 1'b1,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    dist_uart_formatter_if.master bus
);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CONV, LOAD, WAIT_ACK, WAIT_DONE} state_t;

    state_t        state;
    logic [7:0]    cur;
    logic [7:0]    pend;
    logic          pend_v;
    logic [3:0]    hund;
    logic [3:0]    tens;
    logic [3:0]    ones;
    logic [2:0]    idx;
    logic [CW-1:0] tcnt;
    logic [7:0]    byte_sel;
    logic          advance;
    logic          last;
    logic          capture;

    always_comb begin
        byte_sel = 8'h00;
        case (idx)
            3'd0:    byte_sel = (BLANK_ZERO && hund == 4'd0) ? 8'h20 : {4'h3, hund};
            3'd1:    byte_sel = (BLANK_ZERO && hund == 4'd0 && tens == 4'd0) ? 8'h20 : {4'h3, tens};
            3'd2:    byte_sel = {4'h3, ones};
            3'd3:    byte_sel = 8'h63;
            3'd4:    byte_sel = 8'h6D;
            3'd5:    byte_sel = 8'h0D;
            default: byte_sel = 8'h0A;
        endcase
    end

    // A missing ack is treated exactly like a completed byte.
    assign advance = (state == WAIT_ACK && !bus.tx_busy && tcnt == CW'(ACK_TIMEOUT))
                  || (state == WAIT_DONE && !bus.tx_busy);
    assign last    = (idx == 3'd6);
    assign capture = advance && last && pend_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cur          <= 8'h00;
            pend         <= 8'h00;
            pend_v       <= 1'b0;
            hund         <= 4'd0;
            tens         <= 4'd0;
            ones         <= 4'd0;
            idx          <= 3'd0;
            tcnt         <= '0;
            bus.tx_start <= 1'b0;
            bus.tx_data  <= 8'h00;
            bus.sending  <= 1'b0;
            bus.overrun  <= 1'b0;
        end else begin
            bus.tx_start <= 1'b0;
            bus.sending  <= (state != IDLE);

            case (state)
                IDLE: begin
                    if (bus.done) begin
                        cur   <= bus.dist_data;
                        state <= CONV;
                    end else if (pend_v) begin
                        cur    <= pend;
                        pend_v <= 1'b0;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    hund        <= 4'(cur / 8'd100);
                    tens        <= 4'((cur / 8'd10) % 8'd10);
                    ones        <= 4'(cur % 8'd10);
                    idx         <= 3'd0;
                    bus.overrun <= 1'b0;
                    state       <= LOAD;
                end
                LOAD: begin
                    if (!bus.tx_busy) begin
                        bus.tx_start <= 1'b1;
                        bus.tx_data  <= byte_sel;
                        tcnt         <= CW'(1);
                        state        <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (bus.tx_busy)
                        state <= WAIT_DONE;
                    else if (!advance)
                        tcnt <= tcnt + 1'b1;
                end
                WAIT_DONE: ;
                default: state <= IDLE;
            endcase

            if (advance) begin
                if (!last) begin
                    idx   <= idx + 3'd1;
                    state <= LOAD;
                end else if (pend_v) begin
                    cur   <= pend;
                    state <= CONV;
                end else begin
                    state <= IDLE;
                end
            end

            // A same-cycle capture frees the slot, so the newcomer is not an overrun.
            if (bus.done && state != IDLE) begin
                pend   <= bus.dist_data;
                pend_v <= 1'b1;
                if (pend_v && !capture)
                    bus.overrun <= 1'b1;
            end else if (capture) begin
                pend_v <= 1'b0;
            end
        end
    end
endmodule

// File: doc/dist_uart_formatter.md
# dist_uart_formatter

Downstream consumer of the ultrasonic distance path. On each `done` pulse it captures the 8-bit distance in centimetres and streams it as a 7-byte ASCII frame (three decimal digits, "cm", CR, LF) into the existing UART transmitter through a start/busy handshake. It absorbs one measurement that arrives while a frame is in flight and flags any further overrun.

## Interface
Parameters:
- `BLANK_ZERO`, 1: 1 replaces leading zeros with space (0x20); the ones digit is always printed. 0 prints all three digits.
- `ACK_TIMEOUT`, 16: clocks to wait for `tx_busy` to rise after `tx_start` before treating the byte as sent.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `dist_data`  in  8  distance in cm, 0–255, valid in the cycle `done` is high
- `done`  in  1  single-cycle measurement-complete pulse
- `tx_busy`  in  1  UART TX busy; rises the cycle after an accepted `tx_start`, falls when the byte is finished
- `tx_start`  out  1  single-cycle request to send `tx_data`
- `tx_data`  out  8  byte to transmit; valid while `tx_start` is high
- `sending`  out  1  high from the cycle after a frame is captured until its LF completes
- `overrun`  out  1  sticky; set when a pending measurement is overwritten, cleared at the start of the next frame

## Operation
- States: IDLE, CONV, LOAD, WAIT_ACK, WAIT_DONE.
- IDLE: on `done`, latch `dist_data` into `cur`, then go to CONV.
- CONV, 1 cycle: hundreds = cur/100, tens = (cur/10)%10, ones = cur%10. These are 4-bit registers, each 0–9; hundreds is 0–2. Build the byte sequence H, T, O, 0x63, 0x6D, 0x0D, 0x0A using a 3-bit index `idx` that starts at 0. Clear `overrun`. Go to LOAD.
- Digit encoding is 0x30 + digit. With BLANK_ZERO=1:
  - H is 0x20 if hundreds==0.
  - T is 0x20 if hundreds==0 and tens==0.
- LOAD:
  - While `tx_busy`=1, wait.
  - When `tx_busy`=0, drive `tx_start`=1 for one cycle with `tx_data`=byte[idx], load the timeout counter, and go to WAIT_ACK.
- WAIT_ACK:
  - `tx_busy`=1 → WAIT_DONE.
  - If the counter reaches ACK_TIMEOUT, treat the byte as done and advance (same as WAIT_DONE exit).
- WAIT_DONE:
  - On `tx_busy`=0, advance.
  - Advance: if idx<6, increment idx and go to LOAD. If idx==6, the frame is complete: go to CONV if a measurement is pending (load `cur` from the pending buffer and clear pending), else go to IDLE.
- Pending buffer, one deep:
  - A `done` in any state other than IDLE writes `dist_data` to `pend` and sets `pend_v`.
  - If `pend_v` is already set, `pend` is overwritten (newest value wins) and `overrun` is set.
  - If the capture from `pend` into `cur` and a new `done` fall in the same cycle, the new value goes to `pend`, `pend_v` stays 1, and `overrun` is not set.
- `sending` = (state != IDLE).
- `tx_start`, `tx_data`, `sending` and `overrun` are all registered.

## Timing
- Reset values: state IDLE; `tx_start`=0, `tx_data`=0x00, `sending`=0, `overrun`=0; `pend_v`=0; `idx`=0.
- Reset asserted mid-frame aborts the frame immediately. No further `tx_start` occurs until a new `done` after reset is released.
- If `done` is sampled at edge N:
  - `sending`=1 after edge N+1.
  - With `tx_busy` low, the first `tx_start` is high during the cycle after edge N+2.
- `tx_start` is never high in two consecutive cycles. It is never asserted while `tx_busy`=1.
- Back-to-back bytes with an ideal TX (busy rises next cycle) have a minimum spacing of the TX byte time + 2 clocks.
- `sending` falls one edge after the final `tx_busy` fall when nothing is pending. If a measurement is pending, `sending` stays high continuously into the next frame.
- Timeout counter width is clog2(ACK_TIMEOUT+1). With ACK_TIMEOUT=16, a missing ack advances the frame 16 clocks after `tx_start`.

## Test plan
- BLANK_ZERO=1, `done` with dist=123, TX model with busy 10 clocks → bytes 0x31 0x32 0x33 0x63 0x6D 0x0D 0x0A in order. Exactly 7 `tx_start` pulses; `sending` returns to 0; `overrun`=0.
- BLANK_ZERO=1, dist=5 then dist=0 → 0x20 0x20 0x35 … and 0x20 0x20 0x30 …. BLANK_ZERO=0, dist=7 → 0x30 0x30 0x37 …. dist=255 → 0x32 0x35 0x35 ….
- dist=100 frame; `done` with 42 during byte 3 → second frame "_42cm\r\n" (0x20 0x34 0x32 …) follows without `sending` dropping; `overrun`=0.
- During a frame, `done` with 10, then 20, then 30 → next frame carries 30; `overrun`=1 after the second overwrite and clears in CONV of the next frame.
- TX model never raises busy, ACK_TIMEOUT=16 → 7 `tx_start` pulses spaced 17 clocks apart, then IDLE.
- Assert `rst` after the 3rd byte of a frame for 2 cycles → all outputs go to reset values immediately. No `tx_start` afterwards until a new `done`; the next frame starts at byte 0.
